// File: rtl/lmem_decode_sequencer.sv
// Lmem decode sequencer: loads a codeword, runs layered read/drain passes
// per iteration with early termination, then unloads hard decisions.
// Every output is a register; writes come from a read-delay line.
module lmem_decode_sequencer #(
  parameter int ADDRDEPTH      = 20,
  parameter int ADDRESSWIDTH   = 5,
  parameter int LAYERS         = 2,
  parameter int LAYERWIDTH     = 1,
  parameter int PIPESTAGES     = 15,
  parameter int PIPECOUNTWIDTH = 4,
  parameter int MAXITRS        = 10,
  parameter int ITRWIDTH       = 4,
  parameter int LOADDEPTH      = 16,
  parameter int UNLOADDEPTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    converged,
  output logic                    loaden,
  output logic                    rd_en,
  output logic [ADDRESSWIDTH-1:0] rd_address,
  output logic [LAYERWIDTH-1:0]   rd_layer,
  output logic                    wr_en,
  output logic [LAYERWIDTH-1:0]   wr_layer,
  output logic                    firstprocessing_indicate,
  output logic                    unload_en,
  output logic [ADDRESSWIDTH-1:0] unloadAddress,
  output logic [ITRWIDTH-1:0]     itr_count,
  output logic                    busy,
  output logic                    done
);

  // One counter serves LOAD, READ and UNLOAD, so size it for the longest.
  localparam int MAX_LR  = (LOADDEPTH > ADDRDEPTH) ? LOADDEPTH : ADDRDEPTH;
  localparam int SEQMAX  = (MAX_LR > UNLOADDEPTH) ? MAX_LR : UNLOADDEPTH;
  localparam int CNTW    = $clog2(SEQMAX + 1);

  typedef enum logic [2:0] {IDLE, LOAD, READ, DRAIN, UNLOAD, DONE} state_t;

  state_t                    state_q, state_d;
  logic [CNTW-1:0]           cnt_q, cnt_d;
  logic [PIPECOUNTWIDTH-1:0] drain_q, drain_d;
  logic [LAYERWIDTH-1:0]     layer_q, layer_d;
  logic [ITRWIDTH-1:0]       itr_q, itr_d, itr_inc;

  logic                      loaden_q, rd_en_q, rd_fp_q, fp_q, unload_en_q, busy_q, done_q;
  logic [ADDRESSWIDTH-1:0]   rd_address_q, unload_addr_q;
  logic [LAYERWIDTH-1:0]     rd_layer_q;
  logic                      loaden_d, rd_en_d, rd_fp_d, fp_d, unload_en_d, busy_d, done_d;
  logic [ADDRESSWIDTH-1:0]   rd_address_d, unload_addr_d;
  logic [LAYERWIDTH-1:0]     rd_layer_d;

  // Write delay line: stage k holds the read issued k+1 cycles earlier.
  logic [PIPESTAGES-1:0]                 wr_v_q;
  logic [PIPESTAGES-1:0]                 wr_fp_q;
  logic [PIPESTAGES-1:0][LAYERWIDTH-1:0] wr_l_q;

  // Next-state, counters and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    layer_d = layer_q;
    itr_d   = itr_q;
    itr_inc = (itr_q == ITRWIDTH'(MAXITRS)) ? itr_q : itr_q + ITRWIDTH'(1);
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = LOAD;
          itr_d   = '0;
          layer_d = '0;
        end
      end
      LOAD: begin
        if (cnt_q == CNTW'(LOADDEPTH - 1)) begin
          cnt_d   = '0;
          state_d = READ;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      READ: begin
        if (cnt_q == CNTW'(ADDRDEPTH - 1)) begin
          cnt_d   = '0;
          drain_d = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      DRAIN: begin
        if (drain_q == PIPECOUNTWIDTH'(PIPESTAGES - 1)) begin
          drain_d = '0;
          if (layer_q != LAYERWIDTH'(LAYERS - 1)) begin
            layer_d = layer_q + LAYERWIDTH'(1);
            state_d = READ;
          end else begin
            // End of an iteration: converged is only looked at here.
            layer_d = '0;
            itr_d   = itr_inc;
            state_d = (converged || itr_inc == ITRWIDTH'(MAXITRS)) ? UNLOAD : READ;
          end
        end else begin
          drain_d = drain_q + PIPECOUNTWIDTH'(1);
        end
      end
      UNLOAD: begin
        if (cnt_q == CNTW'(UNLOADDEPTH - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    loaden_d      = (state_d == LOAD);
    rd_en_d       = (state_d == READ);
    rd_address_d  = rd_en_d ? ADDRESSWIDTH'(cnt_d) : '0;
    rd_layer_d    = rd_en_d ? layer_d : '0;
    rd_fp_d       = rd_en_d && (itr_d == '0);
    unload_en_d   = (state_d == UNLOAD);
    unload_addr_d = unload_en_d ? ADDRESSWIDTH'(cnt_d) : '0;
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == DONE);
    // The flag is asserted for a read of iteration 0 or for a write whose
    // read was in iteration 0; the latter is one stage from the line's end.
    fp_d          = rd_fp_d || (wr_v_q[PIPESTAGES-2] && wr_fp_q[PIPESTAGES-2]);
  end

  // State, counters, output registers and the write delay line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      drain_q       <= '0;
      layer_q       <= '0;
      itr_q         <= '0;
      loaden_q      <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_address_q  <= '0;
      rd_layer_q    <= '0;
      rd_fp_q       <= 1'b0;
      fp_q          <= 1'b0;
      unload_en_q   <= 1'b0;
      unload_addr_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      wr_v_q        <= '0;
      wr_fp_q       <= '0;
      wr_l_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      drain_q       <= drain_d;
      layer_q       <= layer_d;
      itr_q         <= itr_d;
      loaden_q      <= loaden_d;
      rd_en_q       <= rd_en_d;
      rd_address_q  <= rd_address_d;
      rd_layer_q    <= rd_layer_d;
      rd_fp_q       <= rd_fp_d;
      fp_q          <= fp_d;
      unload_en_q   <= unload_en_d;
      unload_addr_q <= unload_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      wr_v_q        <= {wr_v_q[PIPESTAGES-2:0], rd_en_q};
      wr_fp_q       <= {wr_fp_q[PIPESTAGES-2:0], rd_fp_q};
      wr_l_q        <= {wr_l_q[PIPESTAGES-2:0], rd_layer_q};
    end
  end

  assign loaden                   = loaden_q;
  assign rd_en                    = rd_en_q;
  assign rd_address               = rd_address_q;
  assign rd_layer                 = rd_layer_q;
  assign wr_en                    = wr_v_q[PIPESTAGES-1];
  assign wr_layer                 = wr_l_q[PIPESTAGES-1];
  assign firstprocessing_indicate = fp_q;
  assign unload_en                = unload_en_q;
  assign unloadAddress            = unload_addr_q;
  assign itr_count                = itr_q;
  assign busy                     = busy_q;
  assign done                     = done_q;

endmodule

// File: tb/tb_lmem_decode_sequencer.sv
// Scoreboard bench for lmem_decode_sequencer: the driver pushes the expected
// cycle-by-cycle events of each codeword; a negedge monitor pops and compares.
module tb_lmem_decode_sequencer;

  logic       clk, rst, start, converged;
  logic       loaden, rd_en, wr_en, firstprocessing_indicate, unload_en, busy, done;
  logic [4:0] rd_address, unloadAddress;
  logic [0:0] rd_layer, wr_layer;
  logic [3:0] itr_count;

  lmem_decode_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .converged(converged),
    .loaden(loaden), .rd_en(rd_en), .rd_address(rd_address), .rd_layer(rd_layer),
    .wr_en(wr_en), .wr_layer(wr_layer),
    .firstprocessing_indicate(firstprocessing_indicate),
    .unload_en(unload_en), .unloadAddress(unloadAddress),
    .itr_count(itr_count), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle c is the interval after the c-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int addr;
    int layer;
    int fp;
    int itr;
  } ev_t;

  ev_t q_load[$];
  ev_t q_rd[$];
  ev_t q_wr[$];
  ev_t q_unl[$];
  ev_t q_done[$];

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  int run_lo = 32'h7fffffff;
  int run_hi = -1;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, cyc, act, exp_v);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s unexpected output at cycle=%0d", nm, cyc);
  endtask

  function automatic int outs_vec();
    return int'({loaden, rd_en, rd_address, rd_layer, wr_en, wr_layer,
                 firstprocessing_indicate, unload_en, unloadAddress,
                 itr_count, busy, done});
  endfunction

  function automatic ev_t mk(input int c, input int a, input int l, input int f, input int i);
    ev_t e;
    e.c = c; e.addr = a; e.layer = l; e.fp = f; e.itr = i;
    return e;
  endfunction

  // Expected schedule for a start in cycle s: loads s+1..s+16, iteration i
  // layer l reads from s+17+70i+35l (20 cycles), each write 15 cycles after
  // its read, unload at s+17+70n for 16 cycles, done right after.
  // With ab>=0 the run is aborted by reset and only events up to ab remain.
  task automatic push_run(input int s, input int n, input int ab);
    int rs;
    run_lo = s + 1;
    run_hi = (ab >= 0) ? ab : s + 17 + 70 * n + 16;
    for (int k = 1; k <= 16; k++)
      if (ab < 0 || s + k <= ab) q_load.push_back(mk(s + k, 0, 0, 0, 0));
    for (int i = 0; i < n; i++) begin
      for (int l = 0; l < 2; l++) begin
        rs = s + 17 + 70 * i + 35 * l;
        for (int a = 0; a < 20; a++) begin
          if (ab < 0 || rs + a <= ab)
            q_rd.push_back(mk(rs + a, a, l, (i == 0) ? 1 : 0, i));
        end
      end
    end
    for (int i = 0; i < n; i++) begin
      for (int l = 0; l < 2; l++) begin
        rs = s + 17 + 70 * i + 35 * l;
        for (int a = 0; a < 20; a++) begin
          if (ab < 0 || rs + a + 15 <= ab)
            q_wr.push_back(mk(rs + a + 15, a, l, (i == 0) ? 1 : 0, i));
        end
      end
    end
    if (ab < 0) begin
      for (int a = 0; a < 16; a++)
        q_unl.push_back(mk(s + 17 + 70 * n + a, a, 0, 0, n));
      q_done.push_back(mk(s + 17 + 70 * n + 16, 0, 0, 0, n));
    end
  endtask

  // Monitor: compares DUT activity against the heads of the queues.
  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      chk("busy", int'(busy), (cyc >= run_lo && cyc <= run_hi) ? 1 : 0);
      chk("one_hot", (int'(loaden) + int'(rd_en) + int'(unload_en) <= 1) ? 1 : 0, 1);
      chk("wr_excl", (wr_en && (loaden || unload_en)) ? 1 : 0, 0);
      if (loaden) begin
        if (q_load.size() == 0) unexpected("loaden");
        else begin
          e = q_load.pop_front();
          chk("load_cyc", cyc, e.c);
        end
      end
      if (rd_en) begin
        if (q_rd.size() == 0) unexpected("rd_en");
        else begin
          e = q_rd.pop_front();
          chk("rd_cyc", cyc, e.c);
          chk("rd_addr", int'(rd_address), e.addr);
          chk("rd_layer", int'(rd_layer), e.layer);
          chk("rd_fp", int'(firstprocessing_indicate), e.fp);
          chk("rd_itr", int'(itr_count), e.itr);
        end
      end
      if (wr_en) begin
        if (q_wr.size() == 0) unexpected("wr_en");
        else begin
          e = q_wr.pop_front();
          chk("wr_cyc", cyc, e.c);
          chk("wr_layer", int'(wr_layer), e.layer);
          chk("wr_fp", int'(firstprocessing_indicate), e.fp);
        end
      end
      if (unload_en) begin
        if (q_unl.size() == 0) unexpected("unload_en");
        else begin
          e = q_unl.pop_front();
          chk("unl_cyc", cyc, e.c);
          chk("unl_addr", int'(unloadAddress), e.addr);
          chk("unl_itr", int'(itr_count), e.itr);
        end
      end
      if (done) begin
        if (q_done.size() == 0) unexpected("done");
        else begin
          e = q_done.pop_front();
          chk("done_cyc", cyc, e.c);
          chk("done_itr", int'(itr_count), e.itr);
        end
      end
    end
  end

  // Advance to just after the rising edge that starts cycle c.
  task automatic wait_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input int c);
    wait_cycle(c);
    start = 1'b1;
    wait_cycle(c + 1);
    start = 1'b0;
  endtask

  initial begin
    int s;
    int r;
    rst = 1'b0;
    start = 1'b0;
    converged = 1'b0;

    // Reset state.
    wait_cycle(3);
    chk("reset_outputs", outs_vec(), 0);
    rst = 1'b1;
    mon_en = 1'b1;

    // Full 10-iteration decode, with start pulses in READ and UNLOAD ignored.
    s = cyc + 3;
    push_run(s, 10, -1);
    $display("run A: start at %0d, no convergence", s);
    pulse_start(s);
    pulse_start(s + 20);
    pulse_start(s + 17 + 700 + 5);
    wait_cycle(s + 733 + 5);
    chk("itr_hold_A", int'(itr_count), 10);

    // Early termination: converged in the last DRAIN cycle of the 3rd iteration.
    s = cyc + 3;
    push_run(s, 3, -1);
    $display("run B: start at %0d, converged at %0d", s, s + 16 + 210);
    pulse_start(s);
    wait_cycle(s + 16 + 210);
    converged = 1'b1;
    wait_cycle(s + 17 + 210);
    converged = 1'b0;
    wait_cycle(s + 17 + 210 + 16 + 5);
    chk("itr_hold_B", int'(itr_count), 3);

    // Reset for one cycle midway through the first DRAIN.
    s = cyc + 3;
    r = s + 44;
    push_run(s, 1, r);
    $display("run C: start at %0d, reset in cycle %0d", s, r);
    pulse_start(s);
    wait_cycle(r);
    rst = 1'b0;
    wait_cycle(r + 1);
    rst = 1'b1;
    chk("mid_reset_outputs", outs_vec(), 0);
    wait_cycle(r + 40);

    // Fresh decode after the abort, converging after one iteration.
    s = cyc + 3;
    push_run(s, 1, -1);
    $display("run D: start at %0d, converged at %0d", s, s + 86);
    pulse_start(s);
    wait_cycle(s + 86);
    converged = 1'b1;
    wait_cycle(s + 87);
    converged = 1'b0;
    wait_cycle(s + 87 + 16 + 5);
    chk("itr_hold_D", int'(itr_count), 1);

    chk("load_left", q_load.size(), 0);
    chk("rd_left", q_rd.size(), 0);
    chk("wr_left", q_wr.size(), 0);
    chk("unl_left", q_unl.size(), 0);
    chk("done_left", q_done.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lmem_decode_sequencer.md
LMEM_DECODE_SEQUENCER -- requirements
Module: lmem_decode_sequencer

Interface
REQ-001 SHALL have parameter ADDRDEPTH, default 20: Lmem rows per layer, i.e. ceil(Z/P) with Z=511 and P=26.
REQ-002 SHALL have parameter ADDRESSWIDTH, default 5: width of the row and unload address ports.
REQ-003 SHALL have parameter LAYERS, default 2: number of layers per iteration, with LAYERWIDTH 1 for the layer ports.
REQ-004 SHALL have parameter PIPESTAGES, default 15: read-to-write latency (memrd + 13 RCU stages + memwr), with PIPECOUNTWIDTH 4.
REQ-005 SHALL have parameter MAXITRS, default 10, and ITRWIDTH, default 4: maximum iterations and the iteration counter width.
REQ-006 SHALL have parameters LOADDEPTH, default 16, and UNLOADDEPTH, default 16: cycles needed to load and to unload Lmem.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset is synchronous and active-low.
REQ-009 SHALL have port start, input, 1 bit: single-cycle request to decode one codeword.
REQ-010 SHALL have port converged, input, 1 bit: early-termination flag, sampled at the end of each iteration.
REQ-011 SHALL have port loaden, output, 1 bit: Lmem load strobe; upstream presents load_data in the same cycle.
REQ-012 SHALL have ports rd_en (output, 1 bit), rd_address (output, ADDRESSWIDTH) and rd_layer (output, LAYERWIDTH): the Lmem read command.
REQ-013 SHALL have ports wr_en (output, 1 bit) and wr_layer (output, LAYERWIDTH): the Lmem write command.
REQ-014 SHALL have port firstprocessing_indicate, output, 1 bit: high for every read and write of iteration 0.
REQ-015 SHALL have ports unload_en (output, 1 bit) and unloadAddress (output, ADDRESSWIDTH): the hard-decision unload command.
REQ-016 SHALL have ports itr_count (output, ITRWIDTH), busy (output, 1 bit) and done (output, 1 bit): status outputs.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, READ, DRAIN, UNLOAD and DONE, and SHALL register every output.
REQ-018 In IDLE, start=1 SHALL move the FSM to LOAD at the next edge; start SHALL be ignored in every other state.
REQ-019 LOAD SHALL assert loaden for exactly LOADDEPTH consecutive cycles, then enter READ with layer 0 and itr_count 0.
REQ-020 READ SHALL assert rd_en for ADDRDEPTH consecutive cycles, with rd_address 0..ADDRDEPTH-1 ascending and rd_layer equal to the current layer, then enter DRAIN.
REQ-021 A read issued at cycle t SHALL produce wr_en=1 at cycle t+PIPESTAGES, with wr_layer equal to that read's rd_layer, via a PIPESTAGES-deep delay line; firstprocessing_indicate SHALL travel with it.
REQ-022 DRAIN SHALL last exactly PIPESTAGES cycles, so the last write of a layer lands in the final DRAIN cycle and the reads of layer L+1 never overlap the writes of layer L.
REQ-023 At the end of DRAIN, if layer < LAYERS-1, the FSM SHALL increment the layer and enter READ.
REQ-024 At the end of DRAIN of the last layer, itr_count SHALL increment (saturating at MAXITRS) and layer SHALL wrap to 0.
REQ-025 After that increment, the FSM SHALL enter UNLOAD if converged=1 in that cycle or itr_count has reached MAXITRS; otherwise it SHALL enter READ.
REQ-026 UNLOAD SHALL assert unload_en for UNLOADDEPTH cycles with unloadAddress 0..UNLOADDEPTH-1, then enter DONE.
REQ-027 DONE SHALL last one cycle with done=1, then return to IDLE; itr_count SHALL hold its final value until the next start.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 At most one of loaden, rd_en and unload_en SHALL be high in any cycle, and wr_en SHALL never be high during LOAD or UNLOAD.

Reset
REQ-030 When rst=0 at an edge, the FSM SHALL go to IDLE and all outputs, counters and the write delay line SHALL become 0, with no residual wr_en afterwards.
REQ-031 Reset applied mid-operation SHALL abort the codeword, and a start after rst returns to 1 SHALL begin a fresh LOAD.

Verification
REQ-032 Default parameters, start at cycle 0, converged=0 -> loaden in cycles 1-16, then 10 iterations of 70 cycles each, unload_en in cycles 717-732, done=1 in cycle 733, itr_count=10.
REQ-033 First READ with rd_address 0..19 in cycles 17-36 -> wr_en in cycles 32-51 with wr_layer=0 and firstprocessing_indicate=1; layer 1 reads start in cycle 52.
REQ-034 converged=1 in the last DRAIN cycle of iteration 3 -> itr_count=3 and UNLOAD starts the next cycle.
REQ-035 rst=0 for one cycle midway through DRAIN -> all outputs 0 the next cycle and no wr_en until after a new start.
REQ-036 start pulses during READ and UNLOAD -> ignored, with cycle counts identical to REQ-032.
